// File: rtl/tetris_pkg.sv
// Shared constants for the Tetris core: FSM state codes and
// default tick timing for the 10 MHz system clock.
package tetris_pkg;

    // Tick generator FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    // Default timing at 10 MHz
    localparam int unsigned DEF_BASE_PERIOD = 10000000;
    localparam int unsigned DEF_LEVEL_STEP  = 600000;
    localparam int unsigned DEF_MIN_PERIOD  = 1000000;

    localparam int unsigned DEF_CNT_W      = 32;
    localparam int unsigned DEF_LEVEL_W    = 4;
    localparam int unsigned DEF_FAST_SHIFT = 3;

endpackage

// File: rtl/tick_period_calc.sv
// Combinational level/fast_drop -> effective tick period.
// Ports: level, fast_drop in; p_eff out (never below 1).
module tick_period_calc
    import tetris_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned BASE_PERIOD = DEF_BASE_PERIOD,
    parameter int unsigned LEVEL_W     = DEF_LEVEL_W,
    parameter int unsigned LEVEL_STEP  = DEF_LEVEL_STEP,
    parameter int unsigned MIN_PERIOD  = DEF_MIN_PERIOD,
    parameter int unsigned FAST_SHIFT  = DEF_FAST_SHIFT
) (
    input  logic [LEVEL_W-1:0] level,
    input  logic               fast_drop,
    output logic [CNT_W-1:0]   p_eff
);

    localparam int unsigned RW = CNT_W + LEVEL_W;

    localparam logic [RW-1:0] SPAN =
        RW'(BASE_PERIOD - MIN_PERIOD);
    localparam logic [RW-1:0] STEP =
        RW'(LEVEL_STEP);
    localparam logic [CNT_W-1:0] BASE =
        CNT_W'(BASE_PERIOD);
    localparam logic [CNT_W-1:0] FLOOR =
        CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] ONE =
        CNT_W'(1);

    logic [RW-1:0]    red;
    logic [CNT_W-1:0] p_lvl;
    logic [CNT_W-1:0] p_fast;

    always_comb begin
        // Wide product so high levels cannot wrap
        red = RW'(level) * STEP;

        // Saturate at the floor before subtracting
        if (red >= SPAN) begin
            p_lvl = FLOOR;
        end else begin
            p_lvl = BASE - red[CNT_W-1:0];
        end

        p_fast = p_lvl >> FAST_SHIFT;
        if (p_fast == '0) begin
            p_fast = ONE;
        end

        p_eff = fast_drop ? p_fast : p_lvl;
    end

endmodule

// File: rtl/game_tick_gen.sv
// Game-speed tick generator: one-cycle game_clk strobe whose
// period follows level and fast_drop; pause freezes the phase.
// Ports: clk, rst (async, active-high), ce, restart, level,
// fast_drop in; game_clk, running, paused out.
// Option GAME_TICK_STATS_EN adds tick_count[15:0] output.
module game_tick_gen
    import tetris_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned BASE_PERIOD = DEF_BASE_PERIOD,
    parameter int unsigned LEVEL_W     = DEF_LEVEL_W,
    parameter int unsigned LEVEL_STEP  = DEF_LEVEL_STEP,
    parameter int unsigned MIN_PERIOD  = DEF_MIN_PERIOD,
    parameter int unsigned FAST_SHIFT  = DEF_FAST_SHIFT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               restart,
    input  logic [LEVEL_W-1:0] level,
    input  logic               fast_drop,
    output logic               game_clk,
    output logic               running,
    output logic               paused
`ifdef GAME_TICK_STATS_EN
    ,
    output logic [15:0]        tick_count
`endif
);

    localparam logic [CNT_W-1:0] ONE =
        CNT_W'(1);
    localparam logic [CNT_W-1:0] BASE =
        CNT_W'(BASE_PERIOD);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period_d;
    logic             game_clk_q;
    logic             game_clk_d;
    logic             running_q;
    logic             running_d;
    logic             paused_q;
    logic             paused_d;
    logic             tick_due;

    tick_period_calc #(
        .CNT_W       (CNT_W),
        .BASE_PERIOD (BASE_PERIOD),
        .LEVEL_W     (LEVEL_W),
        .LEVEL_STEP  (LEVEL_STEP),
        .MIN_PERIOD  (MIN_PERIOD),
        .FAST_SHIFT  (FAST_SHIFT)
    ) u_calc (
        .level     (level),
        .fast_drop (fast_drop),
        .p_eff     (period_d)
    );

    // >= rather than == so a shrunk period fires at once
    assign tick_due = (cnt_q >= period_q - ONE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        game_clk_d = 1'b0;

        if (restart) begin
            cnt_d   = '0;
            state_d = ce ? ST_RUN : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (ce) begin
                        state_d = ST_RUN;
                    end
                end
                // Resume edge counts like a normal RUN edge
                ST_RUN, ST_PAUSE: begin
                    if (!ce) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = ST_RUN;
                        if (tick_due) begin
                            game_clk_d = 1'b1;
                            cnt_d      = '0;
                        end else begin
                            cnt_d = cnt_q + ONE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        running_d = (state_d == ST_RUN);
        paused_d  = (state_d == ST_PAUSE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            period_q   <= BASE;
            game_clk_q <= 1'b0;
            running_q  <= 1'b0;
            paused_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            game_clk_q <= game_clk_d;
            running_q  <= running_d;
            paused_q   <= paused_d;
        end
    end

    assign game_clk = game_clk_q;
    assign running  = running_q;
    assign paused   = paused_q;

`ifdef GAME_TICK_STATS_EN
    logic [15:0] tick_count_q;
    logic [15:0] tick_count_d;

    // Counts in step with the strobe it reports
    always_comb begin
        tick_count_d = tick_count_q;
        if (restart) begin
            tick_count_d = '0;
        end else if (game_clk_d) begin
            tick_count_d = tick_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_count_q <= '0;
        end else begin
            tick_count_q <= tick_count_d;
        end
    end

    assign tick_count = tick_count_q;
`endif

endmodule

// File: tb/tb_game_tick_gen.sv
// Self-checking bench for game_tick_gen: expected tick cycles
// are queued as stimulus is applied, observed ticks compared.
module tb_game_tick_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic       restart;
    logic [3:0] level;
    logic       fast_drop;
    logic       game_clk;
    logic       running;
    logic       paused;
`ifdef GAME_TICK_STATS_EN
    logic [15:0] tick_count;
`endif

    int checks = 0;
    int errors = 0;

    int cyc   = 0;
    int obs_n = 0;
    int obs_t [256];
    int rd    = 0;
    int exp_q [$];
    int last  = 0;
    int cur_p = 20;

    game_tick_gen #(
        .CNT_W       (32),
        .BASE_PERIOD (20),
        .LEVEL_W     (4),
        .LEVEL_STEP  (4),
        .MIN_PERIOD  (3),
        .FAST_SHIFT  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .restart   (restart),
        .level     (level),
        .fast_drop (fast_drop),
        .game_clk  (game_clk),
        .running   (running),
        .paused    (paused)
`ifdef GAME_TICK_STATS_EN
        ,
        .tick_count(tick_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the edge index of every observed tick
    always @(negedge clk) begin
        if (!rst && game_clk) begin
            obs_t[obs_n % 256] <= cyc;
            obs_n <= obs_n + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic go_to(input int t);
        while (cyc < t) @(negedge clk);
        #1;
    endtask

    // Queue expected ticks for a new level/fast_drop setting
    task automatic apply_rate(input int lvl, input int fd,
                              input int p, input int n);
        int base;
        level     = 4'(lvl);
        fast_drop = fd[0];
        base      = last;
        if (cur_p == 1) begin
            exp_q.push_back(last + 1);
            base = last + 1;
        end else if (p == 1) begin
            base = last + 1;
        end
        for (int i = 1; i <= n; i++) exp_q.push_back(base + p * i);
        last  = base + p * n;
        cur_p = p;
        go_to(last);
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b0; restart = 1'b0;
        level = 4'd0; fast_drop = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (game_clk !== 1'b0) begin
            errors++;
            $display("FAIL rst_game_clk: got %b, required 0", game_clk);
        end
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL rst_running: got %b, required 0", running);
        end
        checks++;
        if (paused !== 1'b0) begin
            errors++;
            $display("FAIL rst_paused: got %b, required 0", paused);
        end
        rst = 1'b0;
    endtask

    task automatic test_base_period();
        int k;
        int e;
        int o;
        k  = cyc;
        ce = 1'b1;
        for (int i = 1; i <= 3; i++) exp_q.push_back(k + 1 + 20 * i);
        go_to(k + 1);
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL base_running: got %b, required 1", running);
        end
        last  = k + 61;
        cur_p = 20;
        go_to(last);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_n) begin
                errors++;
                $display("FAIL base_tick: missing, required cycle %0d", e);
            end else begin
                o = obs_t[rd % 256]; rd++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL base_tick: cycle %0d, required %0d", o, e);
                end
            end
        end
        checks++;
        if (rd !== obs_n) begin
            errors++;
            $display("FAIL base_extra: %0d ticks, required 0", obs_n - rd);
            rd = obs_n;
        end
    endtask

    task automatic test_levels();
        int lv [3] = '{2, 5, 15};
        int pp [3] = '{12, 3, 3};
        int e;
        int o;
        for (int j = 0; j < 3; j++) begin
            apply_rate(lv[j], 0, pp[j], 4);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (rd >= obs_n) begin
                    errors++;
                    $display("FAIL level_tick: missing, required %0d", e);
                end else begin
                    o = obs_t[rd % 256]; rd++;
                    if (o !== e) begin
                        errors++;
                        $display("FAIL level_tick: L%0d cycle %0d, required %0d",
                                 lv[j], o, e);
                    end
                end
            end
            checks++;
            if (rd !== obs_n) begin
                errors++;
                $display("FAIL level_extra: %0d ticks, required 0", obs_n - rd);
                rd = obs_n;
            end
        end
    endtask

    task automatic test_fast_drop();
        int lv [2] = '{0, 5};
        int pp [2] = '{5, 1};
        int e;
        int o;
        for (int j = 0; j < 2; j++) begin
            apply_rate(lv[j], 1, pp[j], 6);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (rd >= obs_n) begin
                    errors++;
                    $display("FAIL fast_tick: missing, required %0d", e);
                end else begin
                    o = obs_t[rd % 256]; rd++;
                    if (o !== e) begin
                        errors++;
                        $display("FAIL fast_tick: L%0d cycle %0d, required %0d",
                                 lv[j], o, e);
                    end
                end
            end
            checks++;
            if (rd !== obs_n) begin
                errors++;
                $display("FAIL fast_extra: %0d ticks, required 0", obs_n - rd);
                rd = obs_n;
            end
        end
    endtask

    task automatic test_pause();
        int t;
        int e;
        int o;
        apply_rate(0, 0, 20, 1);
        t = last;
        go_to(t + 9);
        ce = 1'b0;
        go_to(t + 10);
        checks++;
        if (paused !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL pause_flags: paused=%b running=%b, required 1 0",
                     paused, running);
        end
        go_to(t + 16);
        ce = 1'b1;
        exp_q.push_back(t + 27);
        exp_q.push_back(t + 47);
        go_to(t + 17);
        checks++;
        if (paused !== 1'b0 || running !== 1'b1) begin
            errors++;
            $display("FAIL resume_flags: paused=%b running=%b, required 0 1",
                     paused, running);
        end
        last = t + 47;
        go_to(last);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_n) begin
                errors++;
                $display("FAIL pause_tick: missing, required %0d", e);
            end else begin
                o = obs_t[rd % 256]; rd++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL pause_tick: cycle %0d, required %0d", o, e);
                end
            end
        end
        checks++;
        if (rd !== obs_n) begin
            errors++;
            $display("FAIL pause_extra: %0d ticks, required 0", obs_n - rd);
            rd = obs_n;
        end
    endtask

    task automatic test_level_shrink();
        int t;
        int e;
        int o;
        t = last;
        go_to(t + 15);
        level = 4'd4;
        exp_q.push_back(t + 17);
        exp_q.push_back(t + 21);
        exp_q.push_back(t + 25);
        last  = t + 25;
        cur_p = 4;
        go_to(last);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_n) begin
                errors++;
                $display("FAIL shrink_tick: missing, required %0d", e);
            end else begin
                o = obs_t[rd % 256]; rd++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL shrink_tick: cycle %0d, required %0d", o, e);
                end
            end
        end
        checks++;
        if (rd !== obs_n) begin
            errors++;
            $display("FAIL shrink_extra: %0d ticks, required 0", obs_n - rd);
            rd = obs_n;
        end
    endtask

    task automatic test_async_reset();
        int k;
        int e;
        int o;
        apply_rate(5, 1, 1, 3);
        checks++;
        if (game_clk !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst_clk: got %b, required 1", game_clk);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (game_clk !== 1'b0 || running !== 1'b0 || paused !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: clk=%b run=%b pause=%b, required 0 0 0",
                     game_clk, running, paused);
        end
        @(negedge clk);
        #1;
        rst = 1'b0; level = 4'd0; fast_drop = 1'b0;
        k = cyc;
        go_to(k + 12);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (running !== 1'b0 || game_clk !== 1'b0) begin
            errors++;
            $display("FAIL midcount_rst: run=%b clk=%b, required 0 0",
                     running, game_clk);
        end
        rst = 1'b0;
        exp_q.push_back(k + 33);
        last  = k + 33;
        cur_p = 20;
        go_to(last);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_n) begin
                errors++;
                $display("FAIL rst_tick: missing, required %0d", e);
            end else begin
                o = obs_t[rd % 256]; rd++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL rst_tick: cycle %0d, required %0d", o, e);
                end
            end
        end
        checks++;
        if (rd !== obs_n) begin
            errors++;
            $display("FAIL rst_extra: %0d ticks, required 0", obs_n - rd);
            rd = obs_n;
        end
    endtask

    task automatic test_restart();
        int t;
        int e;
        int o;
        t = last;
        go_to(t + 18);
        restart = 1'b1;
        go_to(t + 19);
        restart = 1'b0;
        checks++;
        if (running !== 1'b1 || game_clk !== 1'b0) begin
            errors++;
            $display("FAIL restart_state: run=%b clk=%b, required 1 0",
                     running, game_clk);
        end
        exp_q.push_back(t + 39);
        exp_q.push_back(t + 59);
        last = t + 59;
        go_to(last);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_n) begin
                errors++;
                $display("FAIL restart_tick: missing, required %0d", e);
            end else begin
                o = obs_t[rd % 256]; rd++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL restart_tick: cycle %0d, required %0d", o, e);
                end
            end
        end
        checks++;
        if (rd !== obs_n) begin
            errors++;
            $display("FAIL restart_extra: %0d ticks, required 0", obs_n - rd);
            rd = obs_n;
        end
    endtask

`ifdef GAME_TICK_STATS_EN
    task automatic test_stats();
        int n0;
        int lim;
        int want;
        want = 70000 % 65536;
        restart = 1'b1; level = 4'd5; fast_drop = 1'b1;
        go_to(last + 1);
        restart = 1'b0;
        checks++;
        if (tick_count !== 16'd0) begin
            errors++;
            $display("FAIL stats_clear: got %0d, required 0", tick_count);
        end
        n0  = obs_n;
        lim = cyc + 70100;
        while (obs_n - n0 < 70000 && cyc < lim) begin
            @(negedge clk);
            #1;
        end
        ce = 1'b0;
        checks++;
        if (obs_n - n0 !== 70000) begin
            errors++;
            $display("FAIL stats_ticks: got %0d, required 70000", obs_n - n0);
        end
        go_to(cyc + 2);
        checks++;
        if (tick_count !== 16'(want)) begin
            errors++;
            $display("FAIL stats_wrap: got %0d, required %0d", tick_count, want);
        end
        restart = 1'b1;
        go_to(cyc + 1);
        restart = 1'b0;
        checks++;
        if (tick_count !== 16'd0) begin
            errors++;
            $display("FAIL stats_restart: got %0d, required 0", tick_count);
        end
        rd = obs_n;
    endtask
`endif

    initial begin
        test_reset();
        test_base_period();
        test_levels();
        test_fast_drop();
        test_pause();
        test_level_shrink();
        test_async_reset();
        test_restart();
`ifdef GAME_TICK_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
